// File: rtl/dm_pkg.sv
// Shared types and encodings for the memory-stage data access port.
// Consumers import dm_pkg::* for the state enum, size/extend codes and lane helper.
package dm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    DONE   = 3'd4
  } dm_state_e;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [2:0] LD_WORD = 3'd0;
  localparam logic [2:0] LD_LH   = 3'd1;
  localparam logic [2:0] LD_LHU  = 3'd2;
  localparam logic [2:0] LD_LB   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;

  // Little-endian byte lanes touched by a store of the given size.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: lane_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: lane_be = 4'b0001 << addr_lo;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_port_if.sv
// Word-wide data-memory bus between the access port (master) and memory (slave).
// Handshake: bus_req is held with stable address/control/data until the single-cycle
// bus_ack; an ack seen while bus_req is low carries no meaning and is ignored.
interface dm_access_port_if #(parameter int ADDR_W = 32);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dm_load_ext.sv
// Combinational load lane select and sign/zero extension of a fetched word.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dmout_src,
  output logic [31:0] result
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (dmout_src)
      LD_LH:   result = {{16{half_v[15]}}, half_v};
      LD_LHU:  result = {16'h0000, half_v};
      LD_LB:   result = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  result = {24'h000000, byte_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dm_access_port.sv
// Memory-stage data access port: stalls the pipeline across a handshaked bus access.
// Define DM_RMW_EN for a bus without byte enables (sub-word stores become read-merge-write).
module dm_access_port
  import dm_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [1:0]        dmin_src,
  input  logic [2:0]        dmout_src,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              addr_err,
  output logic              stall,
  dm_access_port_if.master  bus,
  output dm_state_e         dbg_state
);

  dm_state_e         state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        lo_q, lo_d;
  logic [2:0]        dmout_q, dmout_d;

  logic              is_half, is_word, is_sub, misaligned;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ext_data;

  dm_load_ext u_load_ext (
    .word      (bus.bus_rdata),
    .addr_lo   (lo_q),
    .dmout_src (dmout_q),
    .result    (ext_data)
  );

`ifdef DM_RMW_EN
  logic [3:0]  lane_be_q, lane_be_d;
  logic [31:0] merged;

  // Store lanes come from the already-steered write data, the rest from memory.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lane_be_q[i] ? bus_wdata_q[8*i +: 8] : bus.bus_rdata[8*i +: 8];
    end
  end
`endif

  always_comb begin
    if (cpu_we) begin
      is_half = (dmin_src == SZ_HALF);
      is_word = (dmin_src != SZ_HALF) && (dmin_src != SZ_BYTE);
    end else begin
      is_half = (dmout_src == LD_LH) || (dmout_src == LD_LHU);
      is_word = !(is_half || (dmout_src == LD_LB) || (dmout_src == LD_LBU));
    end
    is_sub     = cpu_we && !is_word;
    misaligned = (is_half && cpu_addr[0]) || (is_word && (cpu_addr[1:0] != 2'b00));
    st_be      = lane_be(dmin_src, cpu_addr[1:0]);
    case (dmin_src)
      SZ_HALF: st_wdata = {2{cpu_wdata[15:0]}};
      SZ_BYTE: st_wdata = {4{cpu_wdata[7:0]}};
      default: st_wdata = cpu_wdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    lo_d        = lo_q;
    dmout_d     = dmout_q;
`ifdef DM_RMW_EN
    lane_be_d   = lane_be_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          lo_d    = cpu_addr[1:0];
          dmout_d = dmout_src;
          rdata_d = '0;
          err_d   = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = st_wdata;
            if (!cpu_we) begin
              bus_we_d = 1'b0;
              bus_be_d = 4'b1111;
              state_d  = RD;
`ifdef DM_RMW_EN
            end else if (is_sub) begin
              bus_we_d  = 1'b0;
              bus_be_d  = 4'b1111;
              lane_be_d = st_be;
              state_d   = RMW_RD;
            end else begin
              bus_we_d = 1'b1;
              bus_be_d = 4'b1111;
              state_d  = WR;
            end
`else
            end else begin
              bus_we_d = 1'b1;
              bus_be_d = is_sub ? st_be : 4'b1111;
              state_d  = WR;
            end
`endif
          end
        end
      end
      RD: begin
        if (bus_req_q && bus.bus_ack) begin
          bus_req_d = 1'b0;
          rdata_d   = ext_data;
          state_d   = DONE;
        end
      end
`ifdef DM_RMW_EN
      RMW_RD: begin
        // Drop bus_req for one cycle so the write is a separate transaction.
        if (bus_req_q && bus.bus_ack) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b1;
          bus_wdata_d = merged;
          state_d     = WR;
        end
      end
`endif
      WR: begin
        if (!bus_req_q) begin
          bus_req_d = 1'b1;
        end else if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lo_q        <= 2'b00;
      dmout_q     <= LD_WORD;
`ifdef DM_RMW_EN
      lane_be_q   <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      lo_q        <= lo_d;
      dmout_q     <= dmout_d;
`ifdef DM_RMW_EN
      lane_be_q   <= lane_be_d;
`endif
    end
  end

  assign cpu_done      = (state_q == DONE);
  assign cpu_rdata     = cpu_done ? rdata_q : 32'h0;
  assign addr_err      = cpu_done & err_q;
  assign stall         = cpu_req & ~cpu_done;
  assign dbg_state     = state_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dm_access_port.sv
// Self-checking bench for dm_access_port; a bus responder in the driver task acks
// after a programmable delay, expected {addr_err, cpu_rdata} go through exp_q.
module tb_dm_access_port;
  import dm_pkg::*;

  localparam int W = 33;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [1:0]  dmin_src = '0;
  logic [2:0]  dmout_src = '0;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        addr_err;
  logic        stall;
  dm_state_e   dbg_state;

  dm_access_port_if #(.ADDR_W(32)) bus ();

  dm_access_port #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dmin_src  (dmin_src),
    .dmout_src (dmout_src),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .addr_err  (addr_err),
    .stall     (stall),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int compared = 0;
  int mismatched = 0;

  // Observations collected by the driver for each access
  logic [W-1:0] obs_out;
  int           obs_lat, obs_phases, obs_gap;
  logic         obs_timeout, obs_unstable, obs_stall_bad;
  logic [1:0]   obs_we_seq;
  logic [31:0]  obs_rd_addr, obs_wr_addr, obs_wr_data;
  logic [3:0]   obs_wr_be;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] k);
    logic [31:0] s;
    case (k)
      3'd1: begin s = w >> {a[1], 4'b0}; model_load = {{16{s[15]}}, s[15:0]}; end
      3'd2: begin s = w >> {a[1], 4'b0}; model_load = {16'h0, s[15:0]}; end
      3'd3: begin s = w >> {a, 3'b0}; model_load = {{24{s[7]}}, s[7:0]}; end
      3'd4: begin s = w >> {a, 3'b0}; model_load = {24'h0, s[7:0]}; end
      default: model_load = w;
    endcase
  endfunction

  task automatic drive_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] dmin, input logic [2:0] dmout,
                              input logic [31:0] mem, input int delay, input logic keep_req,
                              input logic scramble);
    int wait_n;
    logic in_phase, done;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_be;
    logic s_we;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; dmin_src = dmin; dmout_src = dmout;
    cpu_req = 1'b1;
    obs_out = '0; obs_lat = 0; obs_phases = 0; obs_gap = 0; obs_unstable = 0;
    obs_stall_bad = 0; obs_we_seq = 2'b00; obs_rd_addr = '0; obs_wr_addr = '0;
    obs_wr_data = '0; obs_wr_be = '0;
    wait_n = 0; in_phase = 0; done = 0;
    s_addr = '0; s_wdata = '0; s_be = '0; s_we = 0;
    while (!done && obs_lat < 60) begin
      @(negedge clk);
      obs_lat++;
      bus.bus_ack = 1'b0;
      if (stall !== (cpu_done ? 1'b0 : 1'b1)) obs_stall_bad = 1;
      if (cpu_done) begin
        obs_out = {addr_err, cpu_rdata};
        done = 1;
      end else begin
        if (scramble) begin
          cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom_range(0, 1));
          dmin_src = 2'($urandom_range(0, 3)); dmout_src = 3'($urandom_range(0, 7));
        end
        if (bus.bus_req) begin
          if (!in_phase) begin
            in_phase = 1; wait_n = 0; obs_phases++;
            s_addr = bus.bus_addr; s_wdata = bus.bus_wdata; s_be = bus.bus_be; s_we = bus.bus_we;
            obs_we_seq = {obs_we_seq[0], bus.bus_we};
            if (bus.bus_we) begin
              obs_wr_addr = bus.bus_addr; obs_wr_data = bus.bus_wdata; obs_wr_be = bus.bus_be;
            end else begin
              obs_rd_addr = bus.bus_addr;
            end
          end else if ({s_addr, s_wdata, s_be, s_we} !==
                       {bus.bus_addr, bus.bus_wdata, bus.bus_be, bus.bus_we}) begin
            obs_unstable = 1;
          end
          wait_n++;
          if (wait_n > delay) begin
            bus.bus_ack = 1'b1; bus.bus_rdata = mem; in_phase = 0;
          end
        end else if (obs_phases > 0) begin
          // Stray ack while bus_req is low must be ignored
          obs_gap++;
          bus.bus_ack = 1'b1; bus.bus_rdata = 32'h5A5A_0000;
        end
      end
    end
    obs_timeout = !done;
    if (!keep_req) begin
      cpu_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({bus.bus_req, bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata, cpu_done, cpu_rdata, addr_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: req=%b we=%b be=%b addr=%h wdata=%h done=%b rdata=%h err=%b required all 0",
               bus.bus_req, bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata, cpu_done, cpu_rdata, addr_err);
    end
    compared++;
    if (dbg_state !== IDLE) begin mismatched++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
    cpu_req = 1'b1;
    #1;
    compared++;
    if (stall !== 1'b1) begin mismatched++; $display("FAIL reset_stall: got %b required 1", stall); end
    cpu_req = 1'b0;
    #1;
    compared++;
    if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall_low: got %b required 0", stall); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [31:0] a, m;
    logic [2:0] k;
    int d;
    exp_q.push_back({1'b0, 32'hFFFF_FF80});
    drive_access(1'b0, 32'h13, '0, SZ_WORD, LD_LB, 32'h80FF_1234, 0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v) begin mismatched++; $display("FAIL lb_data: got %h required %h", obs_out, exp_v); end
    compared++;
    if (obs_lat !== 2) begin mismatched++; $display("FAIL lb_latency: got %0d required 2", obs_lat); end
    compared++;
    if (obs_rd_addr !== 32'h10) begin mismatched++; $display("FAIL lb_bus_addr: got %h required 00000010", obs_rd_addr); end
    exp_q.push_back({1'b0, 32'h0000_8001});
    drive_access(1'b0, 32'h12, '0, SZ_WORD, LD_LHU, 32'h8001_0000, 0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v) begin mismatched++; $display("FAIL lhu_data: got %h required %h", obs_out, exp_v); end
    for (int i = 0; i < 8; i++) begin
      k = 3'($urandom_range(0, 7));
      a = 32'h100 + 32'($urandom_range(0, 255));
      if (k == LD_LH || k == LD_LHU) a[0] = 1'b0;
      if (k == LD_WORD || k > LD_LBU) a[1:0] = 2'b00;
      m = $urandom;
      d = $urandom_range(0, 3);
      exp_q.push_back({1'b0, model_load(m, a[1:0], k)});
      drive_access(1'b0, a, '0, SZ_WORD, k, m, d, 1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs_out !== exp_v || obs_timeout) begin
        mismatched++;
        $display("FAIL rand_load[%0d]: k=%0d addr=%h got %h required %h", i, k, a, obs_out, exp_v);
      end
      compared++;
      if (obs_lat !== 2 + d) begin mismatched++; $display("FAIL rand_load_lat[%0d]: got %0d required %0d", i, obs_lat, 2 + d); end
    end
  endtask

  task automatic test_misaligned();
    logic        we_t[3]   = '{1'b0, 1'b0, 1'b1};
    logic [31:0] a_t[3]    = '{32'h11, 32'h42, 32'h23};
    logic [1:0]  dmin_t[3] = '{SZ_WORD, SZ_WORD, SZ_HALF};
    logic [2:0]  dout_t[3] = '{LD_LH, LD_WORD, LD_WORD};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 32'h0});
      drive_access(we_t[i], a_t[i], 32'hFFFF_FFFF, dmin_t[i], dout_t[i], 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs_out !== exp_v) begin mismatched++; $display("FAIL misaligned_out[%0d]: got %h required %h", i, obs_out, exp_v); end
      compared++;
      if (obs_phases !== 0 || obs_lat !== 1) begin
        mismatched++;
        $display("FAIL misaligned_bus[%0d]: phases=%0d lat=%0d required 0 and 1", i, obs_phases, obs_lat);
      end
    end
  endtask

  task automatic test_stores();
    logic [1:0] sz;
    logic [31:0] a, w, exp_d;
    logic [3:0] exp_be;
`ifdef DM_RMW_EN
    exp_q.push_back({1'b0, 32'h0});
    drive_access(1'b1, 32'h22, 32'h7777_BEEF, SZ_HALF, LD_WORD, 32'h1122_3344, 0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v) begin mismatched++; $display("FAIL rmw_sh_out: got %h required %h", obs_out, exp_v); end
    compared++;
    if ({obs_phases, obs_gap, obs_we_seq} !== {32'd2, 32'd1, 2'b01}) begin
      mismatched++;
      $display("FAIL rmw_sh_phases: phases=%0d gap=%0d we_seq=%b required 2 1 01", obs_phases, obs_gap, obs_we_seq);
    end
    compared++;
    if ({obs_wr_addr, obs_wr_data, obs_wr_be} !== {32'h20, 32'hBEEF_3344, 4'b1111}) begin
      mismatched++;
      $display("FAIL rmw_sh_write: addr=%h data=%h be=%b required 00000020 beef3344 1111", obs_wr_addr, obs_wr_data, obs_wr_be);
    end
    compared++;
    if (obs_lat !== 4) begin mismatched++; $display("FAIL rmw_sh_latency: got %0d required 4", obs_lat); end
    drive_access(1'b1, 32'h21, 32'h5555_55AB, SZ_BYTE, LD_WORD, 32'h1122_3344, 1, 1'b0, 1'b0);
    compared++;
    if ({obs_wr_data, obs_wr_be, obs_gap} !== {32'h1122_AB44, 4'b1111, 32'd1}) begin
      mismatched++;
      $display("FAIL rmw_sb_write: data=%h be=%b gap=%0d required 1122ab44 1111 1", obs_wr_data, obs_wr_be, obs_gap);
    end
    drive_access(1'b1, 32'h24, 32'h1234_5678, SZ_WORD, LD_WORD, 32'h0, 0, 1'b0, 1'b0);
    compared++;
    if ({obs_phases, obs_wr_data, obs_wr_be} !== {32'd1, 32'h1234_5678, 4'b1111}) begin
      mismatched++;
      $display("FAIL rmw_sw_write: phases=%0d data=%h be=%b required 1 12345678 1111", obs_phases, obs_wr_data, obs_wr_be);
    end
`else
    exp_q.push_back({1'b0, 32'h0});
    drive_access(1'b1, 32'h21, 32'h5555_55AB, SZ_BYTE, LD_WORD, 32'h0, 0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v) begin mismatched++; $display("FAIL sb_out: got %h required %h", obs_out, exp_v); end
    compared++;
    if ({obs_wr_addr, obs_wr_be, obs_wr_data, obs_we_seq[0]} !== {32'h20, 4'b0010, 32'hABAB_ABAB, 1'b1}) begin
      mismatched++;
      $display("FAIL sb_bus: addr=%h be=%b data=%h we=%b required 00000020 0010 abababab 1",
               obs_wr_addr, obs_wr_be, obs_wr_data, obs_we_seq[0]);
    end
    compared++;
    if (obs_lat !== 2 || obs_phases !== 1) begin
      mismatched++; $display("FAIL sb_timing: lat=%0d phases=%0d required 2 1", obs_lat, obs_phases);
    end
    for (int i = 0; i < 6; i++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'h200 + 32'($urandom_range(0, 63));
      w = $urandom;
      if (sz == SZ_HALF) a[0] = 1'b0;
      if (sz == SZ_WORD || sz == 2'd3) a[1:0] = 2'b00;
      exp_be = (sz == SZ_HALF) ? (4'b0011 << {a[1], 1'b0}) : (sz == SZ_BYTE) ? (4'b0001 << a[1:0]) : 4'hF;
      exp_d  = (sz == SZ_HALF) ? {w[15:0], w[15:0]} : (sz == SZ_BYTE) ? {w[7:0], w[7:0], w[7:0], w[7:0]} : w;
      exp_q.push_back({1'b0, 32'h0});
      drive_access(1'b1, a, w, sz, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2), 1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      compared++;
      if ({obs_out, obs_wr_addr, obs_wr_be, obs_wr_data} !== {exp_v, {a[31:2], 2'b00}, exp_be, exp_d} || obs_timeout) begin
        mismatched++;
        $display("FAIL rand_store[%0d]: sz=%0d out=%h addr=%h be=%b data=%h required %h %h %b %h", i, sz,
                 obs_out, obs_wr_addr, obs_wr_be, obs_wr_data, exp_v, {a[31:2], 2'b00}, exp_be, exp_d);
      end
    end
`endif
  endtask

  task automatic test_slow_ack();
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    drive_access(1'b0, 32'h30, '0, SZ_WORD, LD_WORD, 32'hCAFE_F00D, 5, 1'b0, 1'b1);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v) begin mismatched++; $display("FAIL slow_data: got %h required %h", obs_out, exp_v); end
    compared++;
    if (obs_lat !== 7) begin mismatched++; $display("FAIL slow_latency: got %0d required 7", obs_lat); end
    compared++;
    if ({obs_unstable, obs_stall_bad} !== 2'b00) begin
      mismatched++; $display("FAIL slow_stable: unstable=%b stall_bad=%b required 0 0", obs_unstable, obs_stall_bad);
    end
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    compared++;
    if ({dbg_state, bus.bus_req, cpu_done} !== {IDLE, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL idle_stray_ack: state=%0d req=%b done=%b required IDLE 0 0", dbg_state, bus.bus_req, cpu_done);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    exp_q.push_back({1'b0, 32'h0000_0099});
    drive_access(1'b0, 32'h50, '0, SZ_WORD, LD_WORD, 32'h0BAD_F00D, 0, 1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v || obs_lat !== 2) begin
      mismatched++; $display("FAIL b2b_first: got %h lat %0d required %h lat 2", obs_out, obs_lat, exp_v);
    end
    drive_access(1'b0, 32'h51, '0, SZ_WORD, LD_LBU, 32'h0000_9900, 0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v || obs_lat !== 3) begin
      mismatched++; $display("FAIL b2b_second: got %h lat %0d required %h lat 3", obs_out, obs_lat, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int done_seen;
    cpu_we = 1'b0; cpu_addr = 32'h60; dmin_src = SZ_WORD; dmout_src = LD_WORD;
    cpu_req = 1'b1;
    n = 0;
    while (!bus.bus_req && n < 10) begin @(negedge clk); n++; end
    compared++;
    if (bus.bus_req !== 1'b1) begin mismatched++; $display("FAIL midreset_req_seen: got %b required 1", bus.bus_req); end
    compared++;
    if (dbg_state !== RD) begin mismatched++; $display("FAIL midreset_in_rd: got %0d required RD", dbg_state); end
    reset_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.bus_req, dbg_state, cpu_done} !== {1'b0, IDLE, 1'b0}) begin
      mismatched++;
      $display("FAIL midreset_abort: req=%b state=%0d done=%b required 0 IDLE 0", bus.bus_req, dbg_state, cpu_done);
    end
    reset_n = 1'b1;
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'h1111_1111;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.bus_ack = 1'b0;
      if (cpu_done) done_seen++;
    end
    compared++;
    if (done_seen !== 0) begin mismatched++; $display("FAIL midreset_no_done: got %0d done pulses required 0", done_seen); end
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    drive_access(1'b0, 32'h40, '0, SZ_WORD, LD_WORD, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    compared++;
    if (obs_out !== exp_v || obs_lat !== 2) begin
      mismatched++; $display("FAIL post_reset_lw: got %h lat %0d required %h lat 2", obs_out, obs_lat, exp_v);
    end
  endtask

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    test_reset();
    test_loads();
    test_misaligned();
    test_stores();
    test_slow_ack();
    test_back_to_back();
    test_reset_mid();
    compared++;
    if (exp_q.size() !== 0) begin mismatched++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
